// File: rtl/laser_bank_pkg.sv
// laser_bank_pkg: shared constants for the laser bank.
//   SHOT_W / SHOT_H : shot sprite size in pixels
//   SHOT_VEL        : rows a shot climbs per frame
//   SHOT_COLOR      : 24-bit 0xRRGGBB colour of a shot
//   HRES / VRES     : visible raster size
//   count_ones()    : popcount helper used for the live-shot counter
package laser_bank_pkg;

  localparam int          SHOT_W     = 2;
  localparam int          SHOT_H     = 8;
  localparam int          SHOT_VEL   = 6;
  localparam logic [23:0] SHOT_COLOR = 24'hFF_60_20;
  localparam int          HRES       = 640;
  localparam int          VRES       = 480;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/laser_bank_if.sv
// laser_bank_if: collision bus between the laser bank and the collision logic.
//   hit_valid / hit_idx      : kill request for one slot (collision logic -> bank)
//   shot_x / shot_y / shot_live : per-slot state (bank -> collision logic)
// Modports: master = collision logic, slave = laser_bank.
interface laser_bank_if #(
  parameter int MAX_SHOTS = 4
) ();

  localparam int IW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;

  logic                  hit_valid;
  logic [IW-1:0]         hit_idx;
  logic signed [11:0]    shot_x [MAX_SHOTS];
  logic signed [11:0]    shot_y [MAX_SHOTS];
  logic [MAX_SHOTS-1:0]  shot_live;

  modport master (
    output hit_valid, hit_idx,
    input  shot_x, shot_y, shot_live
  );

  modport slave (
    input  hit_valid, hit_idx,
    output shot_x, shot_y, shot_live
  );

endinterface

// File: rtl/laser_bank_shot_slot.sv
// shot_slot: one laser shot slot (live flag, position, motion, hit test).
//   clk, rst_n        : pixel clock, async active-low reset
//   fsync             : frame-start pulse; moves or spawns the shot
//   kill              : clear the live flag (wins over fsync)
//   spawn, spawn_x/y  : load a new shot on fsync (only asserted when dead)
//   hpos, vpos        : raster position for the hit test
//   live, x, y        : registered slot state
//   hit               : raster position lies inside this live shot
module shot_slot
  import laser_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic               kill,
  input  logic               spawn,
  input  logic signed [11:0] spawn_x,
  input  logic signed [11:0] spawn_y,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  output logic               live,
  output logic signed [11:0] x,
  output logic signed [11:0] y,
  output logic               hit
);

  // One extra bit so a shot near the top shows a negative result.
  logic signed [12:0] y_moved;
  assign y_moved = 13'(y) - 13'(SHOT_VEL);

  // A kill in the fsync cycle freezes the slot: it neither moves nor respawns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else if (kill) begin
      live <= 1'b0;
    end else if (fsync) begin
      if (spawn) begin
        live <= 1'b1;
        x    <= spawn_x;
        y    <= spawn_y;
      end else if (live) begin
        if (y_moved[12]) live <= 1'b0;
        else             y    <= y_moved[11:0];
      end
    end
  end

  logic signed [12:0] h13, v13, x13, y13;
  assign h13 = 13'(hpos);
  assign v13 = 13'(vpos);
  assign x13 = 13'(x);
  assign y13 = 13'(y);

  assign hit = live &&
               (h13 >= x13) && (h13 < x13 + 13'(SHOT_W)) &&
               (v13 >= y13) && (v13 < y13 + 13'(SHOT_H));

endmodule

// File: rtl/laser_bank.sv
// laser_bank: pool of MAX_SHOTS player laser shots.
//   pixel_clk, rst_n      : clock, async active-low reset
//   fsync                 : one-cycle frame-start pulse
//   hpos, vpos            : current raster position
//   fire                  : raw asynchronous fire button
//   paddle_center_x/top   : spawn reference point
//   bus (slave)           : kill requests in, per-slot state out
//   pixel[0:2]            : blue, green, red
//   active                : raster inside any live shot
//   fire_ack              : one-cycle pulse after a spawning fsync
//   shot_count            : registered number of live slots
// Optional feature: define LASER_AUTOFIRE_EN to make a held fire button
// re-arm the request every cycle (auto-repeat limited by the cooldown).
module laser_bank
  import laser_bank_pkg::*;
#(
  parameter int MAX_SHOTS       = 4,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               fire,
  input  logic [11:0]        paddle_center_x,
  input  logic signed [11:0] paddle_top,
  laser_bank_if.slave        bus,
  output logic [7:0]         pixel [0:2],
  output logic               active,
  output logic               fire_ack,
  output logic [3:0]         shot_count
);

  localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [2:0]           fire_sync;
  logic                 fire_set;
  logic                 pending;
  logic [CW-1:0]        cooldown;
  logic [MAX_SHOTS-1:0] live_vec, hit_vec, kill_vec, free_vec;
  logic [MAX_SHOTS-1:0] spawn_vec, spawn_now;
  logic                 free_found, spawn_ok;
  logic signed [11:0]   spawn_x, spawn_y;
  logic signed [11:0]   slot_x [MAX_SHOTS];
  logic signed [11:0]   slot_y [MAX_SHOTS];

`ifdef LASER_AUTOFIRE_EN
  assign fire_set = fire_sync[2];
`else
  logic fire_prev;

  // Previous synchronised level, for rising-edge detection.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) fire_prev <= 1'b0;
    else        fire_prev <= fire_sync[2];
  end

  assign fire_set = fire_sync[2] & ~fire_prev;
`endif

  // Synchroniser and request flag; every fsync consumes the request.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_sync <= '0;
      pending   <= 1'b0;
    end else begin
      fire_sync <= {fire_sync[1:0], fire};
      if (fsync)         pending <= 1'b0;
      else if (fire_set) pending <= 1'b1;
    end
  end

  // A slot being killed this cycle is still live, so it is never free here;
  // masking kill_vec as well keeps that true even for an already-dead slot.
  assign free_vec = ~live_vec & ~kill_vec;

  // Lowest-index free slot wins.
  always_comb begin
    spawn_vec  = '0;
    free_found = 1'b0;
    for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        spawn_vec    = '0;
        spawn_vec[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  assign spawn_ok  = fsync && pending && (cooldown == '0) && free_found;
  assign spawn_now = spawn_ok ? spawn_vec : '0;
  assign spawn_x   = paddle_center_x - 12'(SHOT_W / 2);
  assign spawn_y   = paddle_top - 12'(SHOT_H);

  // Cooldown only moves on fsync; a drop due to a full bank happens at zero.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      cooldown   <= '0;
      fire_ack   <= 1'b0;
      shot_count <= '0;
    end else begin
      fire_ack   <= spawn_ok;
      shot_count <= count_ones(8'(live_vec));
      if (fsync) begin
        if (spawn_ok)             cooldown <= CW'(COOLDOWN_FRAMES);
        else if (cooldown != '0)  cooldown <= cooldown - CW'(1);
      end
    end
  end

  for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_slot
    assign kill_vec[i] = bus.hit_valid && (int'(bus.hit_idx) == i);

    shot_slot u_slot (
      .clk     (pixel_clk),
      .rst_n   (rst_n),
      .fsync   (fsync),
      .kill    (kill_vec[i]),
      .spawn   (spawn_now[i]),
      .spawn_x (spawn_x),
      .spawn_y (spawn_y),
      .hpos    (hpos),
      .vpos    (vpos),
      .live    (live_vec[i]),
      .x       (slot_x[i]),
      .y       (slot_y[i]),
      .hit     (hit_vec[i])
    );

    assign bus.shot_x[i] = slot_x[i];
    assign bus.shot_y[i] = slot_y[i];
  end

  assign bus.shot_live = live_vec;
  assign active        = |hit_vec;
  assign pixel[0]      = active ? SHOT_COLOR[7:0]   : 8'h00;
  assign pixel[1]      = active ? SHOT_COLOR[15:8]  : 8'h00;
  assign pixel[2]      = active ? SHOT_COLOR[23:16] : 8'h00;

endmodule
